// File: rtl/pipe_pkg.sv
// Shared types and helpers for the generic inter-stage pipeline latch.
package pipe_pkg;

  // Number of words held by one stage (0..2).
  typedef logic [1:0] occupancy_t;

  // Largest number of words a stage can hold (main + skid).
  localparam int unsigned OCC_MAX = 2;

  // Count of valid entries, widened to the occupancy type.
  function automatic occupancy_t occ_count(input logic m_valid, input logic s_valid);
    occupancy_t m_w;
    occupancy_t s_w;
    m_w = {1'b0, m_valid};
    s_w = {1'b0, s_valid};
    return m_w + s_w;
  endfunction

endpackage

// File: rtl/pipeline_latch_slot.sv
// One storage entry of the pipeline latch: valid, halt tag and opaque payload.
// Control priority: zero (drop everything, payload to 0) > load > clear
// (drop the word but keep the payload so out_data holds its last value).
module pipeline_latch_slot
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 128
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             zero_i,
  input  logic             load_i,
  input  logic             clear_i,
  input  logic             halt_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic             halt_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q, valid_d;
  logic             halt_q,  halt_d;
  logic [WIDTH-1:0] data_q,  data_d;

  // Next-state selection for the entry.
  always_comb begin
    valid_d = valid_q;
    halt_d  = halt_q;
    data_d  = data_q;
    if (zero_i) begin
      valid_d = 1'b0;
      halt_d  = 1'b0;
      data_d  = '0;
    end else if (load_i) begin
      valid_d = 1'b1;
      halt_d  = halt_i;
      data_d  = data_i;
    end else if (clear_i) begin
      valid_d = 1'b0;
      halt_d  = 1'b0;
    end
  end

  // Entry registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      halt_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      halt_q  <= halt_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign halt_o  = halt_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipeline_latch.sv
// Generic valid/ready pipeline-stage register with optional skid entry,
// synchronous flush and a sticky halt that freezes the stage once a
// halt-tagged word has been handed downstream. Payload is never interpreted.
//
// With SKID=1, in_ready depends only on registered state, so back-pressure
// never forms a combinational path from out_ready to in_ready.
module pipeline_latch
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned SKID  = 1
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_halt,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_halt,
  output logic             halted,
  output occupancy_t       occupancy
);

  logic             m_valid;
  logic             m_halt;
  logic [WIDTH-1:0] m_data;
  logic             s_valid;
  logic             s_halt;
  logic [WIDTH-1:0] s_data;

  logic             m_zero;
  logic             m_load;
  logic             m_clear;
  logic             m_load_halt;
  logic [WIDTH-1:0] m_load_data;

  logic             halted_q, halted_d;
  logic             accept;
  logic             retire;

  // Halted forces the stage invisible in both directions, which also
  // turns accept/retire off and so freezes both entries without extra gating.
  assign out_valid = m_valid & ~halted_q;
  assign retire    = out_valid & out_ready;
  assign accept    = in_valid & in_ready;
  assign out_data  = m_data;
  assign out_halt  = out_valid & m_halt;
  assign halted    = halted_q;
  assign occupancy = occ_count(m_valid, s_valid);

  // Main-entry control: refill from skid first to keep FIFO order.
  always_comb begin
    m_zero      = flush;
    m_load      = 1'b0;
    m_clear     = 1'b0;
    m_load_halt = in_halt;
    m_load_data = in_data;
    if (!flush) begin
      if (retire && s_valid) begin
        m_load      = 1'b1;
        m_load_halt = s_halt;
        m_load_data = s_data;
      end else if ((retire || !m_valid) && accept) begin
        m_load = 1'b1;
      end else if (retire) begin
        m_clear = 1'b1;
      end
    end
  end

  pipeline_latch_slot #(
    .WIDTH (WIDTH)
  ) u_main (
    .clk_i   (CLK),
    .rst_ni  (nRST),
    .zero_i  (m_zero),
    .load_i  (m_load),
    .clear_i (m_clear),
    .halt_i  (m_load_halt),
    .data_i  (m_load_data),
    .valid_o (m_valid),
    .halt_o  (m_halt),
    .data_o  (m_data)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic s_zero;
      logic s_load;
      logic s_clear;

      assign in_ready = ~s_valid & ~halted_q;

      // Skid entry catches a word accepted while main is stalled.
      always_comb begin
        s_zero  = flush;
        s_load  = ~flush & m_valid & ~retire & accept;
        s_clear = ~flush & retire & s_valid;
      end

      pipeline_latch_slot #(
        .WIDTH (WIDTH)
      ) u_skid (
        .clk_i   (CLK),
        .rst_ni  (nRST),
        .zero_i  (s_zero),
        .load_i  (s_load),
        .clear_i (s_clear),
        .halt_i  (in_halt),
        .data_i  (in_data),
        .valid_o (s_valid),
        .halt_o  (s_halt),
        .data_o  (s_data)
      );
    end else begin : g_no_skid
      assign in_ready = ~halted_q & (~m_valid | out_ready);
      assign s_valid  = 1'b0;
      assign s_halt   = 1'b0;
      assign s_data   = '0;
    end
  endgenerate

  // A halt word leaving the stage latches halted; only reset clears it.
  always_comb begin
    halted_d = halted_q | (retire & m_halt);
  end

  // Sticky halt register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end

endmodule

// File: tb/tb_pipeline_latch.sv
// Bench for pipeline_latch: one SKID=1 and one SKID=0 instance, each checked
// every cycle against a small capacity-limited FIFO reference model.
module tb_pipeline_latch;
  import pipe_pkg::*;

  localparam int W = 16;

  logic                CLK = 1'b0;
  logic                nRST;
  logic [1:0]          in_valid, in_halt, flush, out_ready;
  logic [1:0]          in_ready, out_valid, out_halt, halted;
  logic [1:0][W-1:0]   in_data, out_data;
  occupancy_t          occupancy [2];

  always #5 CLK = ~CLK;

  pipeline_latch #(.WIDTH(W), .SKID(1)) u_skid (
    .CLK(CLK), .nRST(nRST),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]), .in_halt(in_halt[0]),
    .flush(flush[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]), .out_halt(out_halt[0]),
    .halted(halted[0]), .occupancy(occupancy[0])
  );

  pipeline_latch #(.WIDTH(W), .SKID(0)) u_noskid (
    .CLK(CLK), .nRST(nRST),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]), .in_halt(in_halt[1]),
    .flush(flush[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]), .out_halt(out_halt[1]),
    .halted(halted[1]), .occupancy(occupancy[1])
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: index 0 holds up to 2 words, index 1 up to 1 word.
  int         m_cnt    [2];
  logic [W:0] m_ent    [2][2];
  logic       m_halted [2];
  logic [W-1:0] m_last [2];
  logic       acc      [2];
  logic [W-1:0] got0[$];
  logic [W-1:0] got1[$];

  function automatic logic exp_ready(input int d);
    if (m_halted[d]) return 1'b0;
    if (d == 0) return m_cnt[d] < 2;
    return (m_cnt[d] == 0) || out_ready[d];
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_cnt[d]    = 0;
      m_halted[d] = 1'b0;
      m_last[d]   = '0;
      m_ent[d][0] = '0;
      m_ent[d][1] = '0;
      acc[d]      = 1'b0;
    end
  endtask

  task automatic idle();
    in_valid = '0; in_halt = '0; flush = '0; in_data = '0;
  endtask

  task automatic set_in(input int d, input logic [W-1:0] data, input logic halt);
    in_valid[d] = 1'b1;
    in_data[d]  = data;
    in_halt[d]  = halt;
  endtask

  // Called just after a falling edge with inputs set; checks, then advances one clock.
  task automatic step();
    logic ret [2];
    logic ev;
    #1;
    for (int d = 0; d < 2; d++) begin
      ev = (m_cnt[d] > 0) && !m_halted[d];
      chk($sformatf("in_ready[%0d]", d),  in_ready[d],  exp_ready(d));
      chk($sformatf("out_valid[%0d]", d), out_valid[d], ev);
      chk($sformatf("out_data[%0d]", d),  out_data[d],
          (m_cnt[d] > 0) ? m_ent[d][0][W-1:0] : m_last[d]);
      chk($sformatf("out_halt[%0d]", d),  out_halt[d],  ev && m_ent[d][0][W]);
      chk($sformatf("halted[%0d]", d),    halted[d],    m_halted[d]);
      chk($sformatf("occupancy[%0d]", d), occupancy[d], m_cnt[d]);
      acc[d] = in_valid[d] && exp_ready(d);
      ret[d] = ev && out_ready[d];
      if (out_valid[d] && out_ready[d]) begin
        if (d == 0) got0.push_back(out_data[d]);
        else        got1.push_back(out_data[d]);
      end
    end
    @(posedge CLK);
    for (int d = 0; d < 2; d++) begin
      if (ret[d] && m_ent[d][0][W]) m_halted[d] = 1'b1;
      if (flush[d]) begin
        m_cnt[d]  = 0;
        m_last[d] = '0;
      end else begin
        if (ret[d]) begin
          m_ent[d][0] = m_ent[d][1];
          m_cnt[d]--;
        end
        if (acc[d]) begin
          m_ent[d][m_cnt[d]] = {in_halt[d], in_data[d]};
          m_cnt[d]++;
        end
        if (m_cnt[d] > 0) m_last[d] = m_ent[d][0][W-1:0];
      end
    end
    @(negedge CLK);
  endtask

  task automatic do_reset();
    idle();
    nRST = 1'b0;
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic chk_reset_vals(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s in_ready[%0d]", tag, d),  in_ready[d],  1'b1);
      chk($sformatf("%s out_valid[%0d]", tag, d), out_valid[d], 1'b0);
      chk($sformatf("%s out_data[%0d]", tag, d),  out_data[d],  '0);
      chk($sformatf("%s out_halt[%0d]", tag, d),  out_halt[d],  1'b0);
      chk($sformatf("%s halted[%0d]", tag, d),    halted[d],    1'b0);
      chk($sformatf("%s occupancy[%0d]", tag, d), occupancy[d], 0);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nxt [2];
    idle();
    out_ready = '0;
    nRST = 1'b0;
    model_reset();
    #12;
    chk_reset_vals("reset");
    @(negedge CLK);
    nRST = 1'b1;
    step();
    step();

    // Back-pressure: fill main and skid, then drain in order.
    out_ready = '0;
    got0.delete(); got1.delete();
    set_in(0, 16'h000A, 1'b0); set_in(1, 16'h000A, 1'b0);
    step();
    set_in(0, 16'h000B, 1'b0); set_in(1, 16'h000B, 1'b0);
    step();
    idle();
    chk("bp occupancy", occupancy[0], 2);
    chk("bp in_ready", in_ready[0], 1'b0);
    chk("bp out_data", out_data[0], 16'h000A);
    step();
    out_ready = 2'b11;
    step(); step(); step();
    chk("bp count0", got0.size(), 2);
    if (got0.size() == 2) begin
      chk("bp first", got0[0], 16'h000A);
      chk("bp second", got0[1], 16'h000B);
    end
    chk("bp count1", got1.size(), 1);

    // Stream 1..8 with out_ready toggling every cycle.
    do_reset();
    got0.delete(); got1.delete();
    nxt[0] = 1; nxt[1] = 1;
    for (int c = 0; c < 80; c++) begin
      if (got0.size() == 8 && got1.size() == 8) break;
      out_ready = (c % 2 == 0) ? 2'b11 : 2'b00;
      for (int d = 0; d < 2; d++) begin
        in_valid[d] = nxt[d] <= 8;
        in_data[d]  = W'(nxt[d]);
        in_halt[d]  = 1'b0;
      end
      step();
      for (int d = 0; d < 2; d++) if (acc[d]) nxt[d]++;
    end
    chk("stream count0", got0.size(), 8);
    chk("stream count1", got1.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < got0.size()) chk($sformatf("stream0 word%0d", i), got0[i], i + 1);
      if (i < got1.size()) chk($sformatf("stream1 word%0d", i), got1[i], i + 1);
    end

    // Flush with a concurrent accept.
    do_reset();
    out_ready = '0;
    got0.delete(); got1.delete();
    set_in(0, 16'h0021, 1'b0); set_in(1, 16'h0021, 1'b0);
    step();
    set_in(0, 16'h0022, 1'b0); set_in(1, 16'h0022, 1'b0);
    step();
    set_in(0, 16'h000C, 1'b0); set_in(1, 16'h000C, 1'b0);
    flush = 2'b11;
    step();
    idle();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("flush occupancy[%0d]", d), occupancy[d], 0);
      chk($sformatf("flush out_data[%0d]", d), out_data[d], 0);
    end
    out_ready = 2'b11;
    step(); step(); step();
    chk("flush drop0", got0.size(), 0);
    chk("flush drop1", got1.size(), 0);

    // Sticky halt.
    do_reset();
    out_ready = 2'b11;
    set_in(0, 16'h0005, 1'b1); set_in(1, 16'h0005, 1'b1);
    step();
    idle();
    step();
    chk("halt set0", halted[0], 1'b1);
    chk("halt set1", halted[1], 1'b1);
    set_in(0, 16'h0077, 1'b0); set_in(1, 16'h0077, 1'b0);
    step(); step(); step();
    flush = 2'b11;
    step();
    idle();
    chk("halt after flush0", halted[0], 1'b1);
    chk("halt after flush1", halted[1], 1'b1);
    do_reset();
    #1;
    chk("halt cleared0", halted[0], 1'b0);
    chk("halt cleared1", halted[1], 1'b0);
    @(negedge CLK);

    // Asynchronous reset while full with an accept in flight.
    out_ready = '0;
    got0.delete(); got1.delete();
    set_in(0, 16'h0031, 1'b0); set_in(1, 16'h0031, 1'b0);
    step();
    set_in(0, 16'h0032, 1'b0); set_in(1, 16'h0032, 1'b0);
    step();
    set_in(0, 16'h0099, 1'b0); set_in(1, 16'h0099, 1'b0);
    #2;
    nRST = 1'b0;
    #1;
    chk_reset_vals("async reset");
    model_reset();
    idle();
    @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    out_ready = 2'b11;
    step(); step(); step();
    chk("async no word0", got0.size(), 0);
    chk("async no word1", got1.size(), 0);

    // Randomised traffic with occasional flush and halt.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int d = 0; d < 2; d++) begin
        in_valid[d]  = $urandom_range(0, 3) != 0;
        in_data[d]   = W'($urandom);
        in_halt[d]   = $urandom_range(0, 40) == 0;
        flush[d]     = $urandom_range(0, 30) == 0;
        out_ready[d] = $urandom_range(0, 2) != 0;
      end
      step();
      if ((m_halted[0] || m_halted[1]) && $urandom_range(0, 5) == 0) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
